mirror_stream_loader: RTL and testbench
=======================================

Name: mirror_stream_loader

Overview:
- Upstream feeder for the combinational mirror/equality checker.
- Deserialises a bit-serial frame of 2*WIDTH bits into operand A (first WIDTH bits) and operand B (next WIDTH bits).
- Computes a registered match flag incrementally as B arrives.
- Presents A, B and match to the downstream stage under a valid/ready handshake.

Parameters:
- WIDTH, 10, operand width in bits (one frame = 2*WIDTH bits)
- CNT_W, 16, width of the saturating good-frame counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort; discards any partial or held frame
- in_valid  in  1  serial bit valid
- in_ready  out  1  loader can accept a bit
- in_bit  in  1  serial data, operand bit 0 first
- in_last  in  1  marks the final bit of a frame
- pair_valid  out  1  pair_a/pair_b/match are valid
- pair_ready  in  1  downstream accepts the pair
- pair_a  out  WIDTH  operand A, feeds checker inputs i_0..i_(WIDTH-1)
- pair_b  out  WIDTH  operand B, feeds checker inputs i_WIDTH..i_(2*WIDTH-1)
- match  out  1  registered: pair_a == pair_b
- err_frame  out  1  one-cycle pulse on framing error
- frames_ok  out  CNT_W  saturating count of delivered pairs

Behaviour:
- Reset (async assert, sync release):
  - state=LOAD_A, cnt=0; a_reg=b_reg=0; match=0.
  - pair_valid=0, err_frame=0, frames_ok=0.
  - in_ready=0 while rst_n low.
- Accept occurs when in_valid & in_ready.
- States:
  - LOAD_A: in_ready=1. On accept: a_reg[cnt]<=in_bit. At cnt==WIDTH-1, go to LOAD_B with cnt<=0 and match<=1.
  - LOAD_B: in_ready=1. On accept: b_reg[cnt]<=in_bit and match<=match & (in_bit==a_reg[cnt]). At cnt==WIDTH-1, go to HOLD.
  - HOLD: in_ready=0, pair_valid=1. pair_a, pair_b and match stay stable until pair_valid & pair_ready. On transfer: frames_ok++ (saturating at all-ones), cnt<=0, go to LOAD_A.
- Latency and throughput:
  - pair_valid rises the cycle after the final bit is accepted.
  - There is one bubble after the transfer cycle, so the minimum frame period is 2*WIDTH+1 cycles.
- Framing:
  - in_last must be 1 exactly on frame bit 2*WIDTH-1.
  - in_last=1 on any earlier accepted bit, or in_last=0 on the final bit, is a framing error:
    - err_frame pulses one cycle;
    - no pair is produced and frames_ok is unchanged;
    - state<=LOAD_A, cnt<=0;
    - the offending bit is discarded.
- in_valid=0 in any state: hold state and cnt; no timeout.
- clear:
  - Highest priority after reset; takes effect on the next edge.
  - Forces LOAD_A, cnt=0, pair_valid=0, match=0, err_frame=0.
  - frames_ok is preserved.
  - If a pair transfer happens in the same cycle as clear, clear wins: the transfer does not count and the pair is dropped.
- Async reset mid-frame: everything returns to reset values immediately, and the partial frame is lost.
- Output register rule: pair_a, pair_b and match hold their values until the next frame starts loading. They are only meaningful while pair_valid=1.

Decomposition:
- Package mirror_pkg:
  - state enum {LOAD_A, LOAD_B, HOLD};
  - default WIDTH constant (10);
  - a localparam helper for counter width, $clog2(WIDTH).
- One natural sub-module, mirror_shift_capture: a WIDTH-bit indexed capture register with write-enable and index, instantiated twice (A and B).
- FSM, match logic, framing check and counter stay in the top module.

Test Plan:
- A=0x155 then B=0x155, in_valid held 1, in_last on bit 19, pair_ready=1 → pair_valid at cycle 21 with pair_a=pair_b=0x155, match=1, frames_ok=1.
- A=0x155, B=0x154 → match=0, pair_b=0x154, pair_valid asserted for exactly 1 cycle.
- in_last asserted on bit 7 → err_frame pulses once, no pair_valid. A following good frame (A=B=0x3FF) → match=1, frames_ok increments by 1 only.
- pair_ready low for 5 cycles in HOLD → in_ready=0 and pair_a/pair_b/match stable throughout. Transfer on cycle 6, then in_ready=1 one cycle later.
- clear asserted at frame bit 14 (mid-LOAD_B) → no pair_valid, no err_frame. The next full frame A=0x001, B=0x200 → match=0.
- rst_n pulsed low at bit 5 with frames_ok=3 → all outputs reset immediately (frames_ok=0, in_ready=0). After release, a good frame produces frames_ok=1.

Source files
------------

// File: rtl/mirror_pkg.sv
// Shared types and sizing helpers for the mirror stream loader.
package mirror_pkg;

    // Operand width used when a parent does not override it.
    localparam int DEFAULT_WIDTH = 10;

    // Loader phases: shifting in A, shifting in B, presenting the pair.
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Width of a bit index into a WIDTH-bit operand (at least one bit).
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mirror_shift_capture.sv
// WIDTH-bit operand register written one addressed bit at a time.
module mirror_shift_capture
    import mirror_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q
);

    // Capture the serial bit into the addressed position; other bits hold.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this storage is reset because the outputs it drives must read zero out of reset.
        if (!rst_n) begin
            q <= '0;
        end else if (wr_en) begin
            // NOTE: non-blocking so every flop samples pre-edge values and order inside the block is irrelevant.
            q[idx] <= bit_in;
        end
    end

endmodule

// File: rtl/mirror_stream_loader.sv
// Bit-serial frame loader: deserialises operands A and B, tracks their
// equality as B arrives, and hands the pair downstream via valid/ready.
module mirror_stream_loader
    import mirror_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [WIDTH-1:0] pair_a,
    output logic [WIDTH-1:0] pair_b,
    output logic             match,
    output logic             err_frame,
    output logic [CNT_W-1:0] frames_ok
);

    localparam int               IDX_W    = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;

    logic accept;
    logic last_bit;
    logic frame_err;
    logic wr_a;
    logic wr_b;

    // Ready in both load phases; forced low while reset is asserted.
    assign in_ready = rst_n && (state != HOLD);

    assign accept    = in_valid && in_ready;
    assign last_bit  = (state == LOAD_B) && (cnt == LAST_IDX);
    // in_last must coincide exactly with the final bit of the frame.
    assign frame_err = accept && (in_last != last_bit);

    // A bit is stored only if it is accepted, well framed and not aborted.
    assign wr_a = accept && !frame_err && !clear && (state == LOAD_A);
    assign wr_b = accept && !frame_err && !clear && (state == LOAD_B);

    mirror_shift_capture #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_cap_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_a),
        .idx    (cnt),
        .bit_in (in_bit),
        .q      (pair_a)
    );

    mirror_shift_capture #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_cap_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_b),
        .idx    (cnt),
        .bit_in (in_bit),
        .q      (pair_b)
    );

    // Frame sequencing, incremental match, framing check and delivery count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_A;
            cnt        <= '0;
            match      <= 1'b0;
            pair_valid <= 1'b0;
            err_frame  <= 1'b0;
            frames_ok  <= '0;
        end else if (clear) begin
            // Abort wins over any accept or transfer in the same cycle.
            state      <= LOAD_A;
            cnt        <= '0;
            match      <= 1'b0;
            pair_valid <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            unique case (state)
                LOAD_A: begin
                    if (accept) begin
                        if (frame_err) begin
                            err_frame <= 1'b1;
                            cnt       <= '0;
                        end else if (cnt == LAST_IDX) begin
                            state <= LOAD_B;
                            cnt   <= '0;
                            match <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        if (frame_err) begin
                            err_frame <= 1'b1;
                            state     <= LOAD_A;
                            cnt       <= '0;
                        end else begin
                            match <= match && (in_bit == pair_a[cnt]);
                            if (cnt == LAST_IDX) begin
                                state      <= HOLD;
                                cnt        <= '0;
                                pair_valid <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (pair_ready) begin
                        state      <= LOAD_A;
                        cnt        <= '0;
                        pair_valid <= 1'b0;
                        if (frames_ok != '1) begin
                            frames_ok <= frames_ok + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= LOAD_A;
                    cnt        <= '0;
                    pair_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mirror_stream_loader.sv
// Directed bench for mirror_stream_loader (WIDTH=10, 3-bit counter so
// saturation is reachable).
module tb_mirror_stream_loader;

    localparam int WIDTH = 10;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             pair_valid;
    logic             pair_ready;
    logic [WIDTH-1:0] pair_a;
    logic [WIDTH-1:0] pair_b;
    logic             match;
    logic             err_frame;
    logic [CNT_W-1:0] frames_ok;

    int errors = 0;
    int checks = 0;

    mirror_stream_loader #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .in_last    (in_last),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_a     (pair_a),
        .pair_b     (pair_b),
        .match      (match),
        .err_frame  (err_frame),
        .frames_ok  (frames_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic last);
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = 0; i < WIDTH; i++) send_bit(a[i], 1'b0);
        for (int i = 0; i < WIDTH; i++) send_bit(b[i], i == WIDTH - 1);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] op;
        logic [CNT_W-1:0] exp_cnt;

        rst_n      = 1'b0;
        clear      = 1'b0;
        pair_ready = 1'b1;
        idle();

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_pair_valid", pair_valid, 0);
        check("rst_match", match, 0);
        check("rst_err", err_frame, 0);
        check("rst_frames_ok", frames_ok, 0);
        check("rst_pair_a", pair_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // Matching frame, 0x155/0x155
        send_frame(10'h155, 10'h155);
        check("t1_pair_valid", pair_valid, 1);
        check("t1_pair_a", pair_a, 10'h155);
        check("t1_pair_b", pair_b, 10'h155);
        check("t1_match", match, 1);
        check("t1_in_ready_hold", in_ready, 0);
        tick();
        check("t1_pair_valid_drop", pair_valid, 0);
        check("t1_frames_ok", frames_ok, 1);
        check("t1_in_ready_back", in_ready, 1);

        // LSB mismatch, 0x155/0x154
        send_frame(10'h155, 10'h154);
        check("t2_pair_valid", pair_valid, 1);
        check("t2_match", match, 0);
        check("t2_pair_b", pair_b, 10'h154);
        tick();
        check("t2_one_cycle_valid", pair_valid, 0);
        check("t2_frames_ok", frames_ok, 2);
        check("t2_b_held", pair_b, 10'h154);
        check("t2_match_held", match, 0);

        // Early in_last on bit 7
        op = 10'h155;
        for (int i = 0; i < 7; i++) send_bit(op[i], 1'b0);
        send_bit(op[7], 1'b1);
        idle();
        check("t3_err_pulse", err_frame, 1);
        check("t3_no_valid", pair_valid, 0);
        tick();
        check("t3_err_clear", err_frame, 0);
        check("t3_frames_ok_kept", frames_ok, 2);
        send_frame(10'h3FF, 10'h3FF);
        check("t3_good_valid", pair_valid, 1);
        check("t3_good_match", match, 1);
        check("t3_good_err", err_frame, 0);
        tick();
        check("t3_frames_ok", frames_ok, 3);

        // Missing in_last on the final bit
        for (int i = 0; i < 2 * WIDTH; i++) send_bit(1'b1, 1'b0);
        idle();
        check("t3b_err_pulse", err_frame, 1);
        check("t3b_no_valid", pair_valid, 0);
        check("t3b_in_ready", in_ready, 1);
        tick();
        check("t3b_err_clear", err_frame, 0);
        check("t3b_frames_ok", frames_ok, 3);

        // Back-pressure: pair_ready low for 5 cycles in HOLD, MSB mismatch
        pair_ready = 1'b0;
        send_frame(10'h0F0, 10'h2F0);
        for (int i = 0; i < 5; i++) begin
            check("t4_in_ready", in_ready, 0);
            check("t4_valid", pair_valid, 1);
            check("t4_pair_a", pair_a, 10'h0F0);
            check("t4_pair_b", pair_b, 10'h2F0);
            check("t4_match", match, 0);
            tick();
        end
        check("t4_still_valid", pair_valid, 1);
        pair_ready = 1'b1;
        tick();
        check("t4_valid_drop", pair_valid, 0);
        check("t4_in_ready_back", in_ready, 1);
        check("t4_frames_ok", frames_ok, 4);

        // clear at frame bit 14 (mid-B)
        op = 10'h155;
        for (int i = 0; i < WIDTH; i++) send_bit(op[i], 1'b0);
        for (int i = 0; i < 4; i++) send_bit(op[i], 1'b0);
        clear = 1'b1;
        send_bit(op[4], 1'b0);
        clear = 1'b0;
        idle();
        check("t5_no_valid", pair_valid, 0);
        check("t5_no_err", err_frame, 0);
        check("t5_match_clr", match, 0);
        check("t5_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_idle_valid", pair_valid, 0);
            check("t5_idle_err", err_frame, 0);
        end
        send_frame(10'h001, 10'h200);
        check("t5_valid", pair_valid, 1);
        check("t5_match", match, 0);
        check("t5_pair_a", pair_a, 10'h001);
        check("t5_pair_b", pair_b, 10'h200);
        check("t5_err", err_frame, 0);
        tick();
        check("t5_frames_ok", frames_ok, 5);

        // clear coinciding with a transfer drops the pair
        pair_ready = 1'b0;
        send_frame(10'h3FF, 10'h3FF);
        check("t5b_valid", pair_valid, 1);
        check("t5b_match", match, 1);
        clear      = 1'b1;
        pair_ready = 1'b1;
        tick();
        clear = 1'b0;
        check("t5b_valid_drop", pair_valid, 0);
        check("t5b_frames_ok_kept", frames_ok, 5);
        check("t5b_match_clr", match, 0);

        // Saturation of the 3-bit counter at 7
        exp_cnt = 3'd5;
        for (int i = 0; i < 3; i++) begin
            send_frame(10'h2AA, 10'h2AA);
            check("sat_valid", pair_valid, 1);
            tick();
            if (exp_cnt != 3'd7) exp_cnt = exp_cnt + 3'd1;
            check("sat_frames_ok", frames_ok, exp_cnt);
        end
        check("sat_final", frames_ok, 7);

        // Async reset mid-frame at bit 5
        op = 10'h3FF;
        for (int i = 0; i < 5; i++) send_bit(op[i], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        idle();
        check("t6_frames_ok", frames_ok, 0);
        check("t6_in_ready", in_ready, 0);
        check("t6_pair_a", pair_a, 0);
        check("t6_pair_valid", pair_valid, 0);
        check("t6_match", match, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_rel_in_ready", in_ready, 1);
        send_frame(10'h155, 10'h155);
        check("t6_valid", pair_valid, 1);
        check("t6_match_good", match, 1);
        tick();
        check("t6_frames_ok_after", frames_ok, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
